// File: rtl/fv_si_wb_checker.sv
// fv_si_wb_checker: single-instruction writeback checker.
// Latches the expected rd result at check_start and then watches the DUT
// register-file write port. It reports pass, mismatch, timeout or spurious
// write verdicts, along with the observed writeback latency.
// Optional feature macro: FV_SI_SPURIOUS_WB_CHECK_EN. It adds the QUIET
// observation window and the fail_spurious detection.
module fv_si_wb_checker #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned QUIET_CYCLES   = 8,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      check_start,
  input  logic                      exp_wr,
  input  logic [REG_ADDR_WIDTH-1:0] exp_rd,
  input  logic [REG_WIDTH-1:0]      exp_value,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0]      wb_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail_mismatch,
  output logic                      fail_timeout,
  output logic                      fail_spurious,
  output logic                      protocol_err,
  output logic [CNT_WIDTH-1:0]      wb_latency
);

  // One counter serves both the writeback timeout and the quiet window,
  // so it is sized for whichever limit is larger.
  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
  localparam int unsigned CW = (CNT_WIDTH > QW) ? CNT_WIDTH : QW;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
  localparam logic [CW-1:0] Q_LIM  = CW'(QUIET_CYCLES);
`endif

`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT_WB, S_QUIET, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT_WB, S_DONE} state_t;
`endif

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_exp_rd;
  logic [REG_WIDTH-1:0]      r_exp_value;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_pass;
  logic                      r_fail_mismatch;
  logic                      r_fail_timeout;
  logic                      r_protocol_err;
  logic [CNT_WIDTH-1:0]      r_wb_latency;
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
  logic                      r_fail_spurious;
  logic                      w_wr_other;
`endif

  logic [CW-1:0] w_cnt_nxt;
  logic          w_wr_nz;
  logic          w_hit;
  logic          w_data_eq;

  // Writes to x0 are architecturally discarded and never count as activity.
  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    w_wr_nz   = wb_valid && (wb_addr != '0);
    w_hit     = w_wr_nz && (wb_addr == r_exp_rd);
    w_data_eq = (wb_data == r_exp_value);
  end

`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
  // Detects a nonzero-register write that does not target the expected rd.
  always_comb begin
    w_wr_other = w_wr_nz && !w_hit;
  end
`endif

  // Check sequencer: state, counter, latched expectation and all verdict outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_exp_rd        <= '0;
      r_exp_value     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_fail_mismatch <= 1'b0;
      r_fail_timeout  <= 1'b0;
      r_protocol_err  <= 1'b0;
      r_wb_latency    <= '0;
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
      r_fail_spurious <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (check_start && (r_state != S_IDLE)) begin
        r_protocol_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (check_start) begin
            r_exp_rd        <= exp_rd;
            r_exp_value     <= exp_value;
            r_pass          <= 1'b0;
            r_fail_mismatch <= 1'b0;
            r_fail_timeout  <= 1'b0;
            r_wb_latency    <= '0;
            r_cnt           <= '0;
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
            r_fail_spurious <= 1'b0;
`endif
            if (exp_wr) begin
              r_state <= S_WAIT_WB;
              r_busy  <= 1'b1;
            end else begin
              // No rd write is expected, so the check passes at once. A
              // spurious write seen in the quiet window revokes the pass.
              r_pass <= 1'b1;
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
              r_state <= S_QUIET;
              r_busy  <= 1'b1;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end
          end
        end

        S_WAIT_WB: begin
          r_cnt <= w_cnt_nxt;
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
          if (w_wr_other) begin
            r_fail_spurious <= 1'b1;
          end
`endif
          if (w_hit) begin
            r_wb_latency <= w_cnt_nxt[CNT_WIDTH-1:0];
            if (w_data_eq) begin
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
              r_pass <= !r_fail_spurious;
`else
              r_pass <= 1'b1;
`endif
            end else begin
              r_fail_mismatch <= 1'b1;
            end
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
            r_state <= S_QUIET;
            r_cnt   <= '0;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
`endif
          end else if (w_cnt_nxt == TO_LIM) begin
            r_fail_timeout <= 1'b1;
            r_state        <= S_DONE;
            r_done         <= 1'b1;
            r_busy         <= 1'b0;
          end
        end

`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
        S_QUIET: begin
          r_cnt <= w_cnt_nxt;
          if (w_wr_nz) begin
            r_fail_spurious <= 1'b1;
            r_pass          <= 1'b0;
          end
          if (w_cnt_nxt == Q_LIM) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
`endif

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Drive the output ports from their registers.
  always_comb begin
    busy          = r_busy;
    done          = r_done;
    pass          = r_pass;
    fail_mismatch = r_fail_mismatch;
    fail_timeout  = r_fail_timeout;
    protocol_err  = r_protocol_err;
    wb_latency    = r_wb_latency;
`ifdef FV_SI_SPURIOUS_WB_CHECK_EN
    fail_spurious = r_fail_spurious;
`else
    fail_spurious = 1'b0;
`endif
  end

endmodule

// File: doc/fv_si_wb_checker.md
# fv_si_wb_checker

Single-instruction writeback checker that consumes the SI launch pulse and the expected architectural result produced by the SI property-signal stage, then watches the DUT register-file writeback port. It reports pass, mismatch, timeout or spurious-write verdicts with the observed writeback latency. It sits directly downstream of the SI capture/prediction logic in the formal core harness, and its verdict outputs feed the assertion layer.

## Interface
- REG_WIDTH, 32, architectural register width (`FV_REG_WIDTH`)
- REG_ADDR_WIDTH, 5, register index width
- TIMEOUT_CYCLES, 64, maximum cycles from launch to the expected rd write
- QUIET_CYCLES, 8, post-writeback observation window (FV_SI_SPURIOUS_WB_CHECK_EN only)
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), latency counter width

- clk  in  1  core clock; all state on posedge
- reset_  in  1  asynchronous, active-low reset
- check_start  in  1  one-cycle pulse: si_en AND any si_check_* asserted
- exp_wr  in  1  instruction architecturally writes rd (0 for stores, or rd==0)
- exp_rd  in  REG_ADDR_WIDTH  expected destination index
- exp_value  in  REG_WIDTH  expected rd value; sampled with check_start
- wb_valid  in  1  DUT regfile write enable
- wb_addr  in  REG_ADDR_WIDTH  DUT write index
- wb_data  in  REG_WIDTH  DUT write data
- busy  out  1  check in progress
- done  out  1  one-cycle verdict pulse
- pass  out  1  sticky verdict: correct
- fail_mismatch  out  1  sticky: rd written with wrong data
- fail_timeout  out  1  sticky: no rd write within TIMEOUT_CYCLES
- fail_spurious  out  1  sticky: unexpected nonzero-reg write
- protocol_err  out  1  sticky: check_start while busy
- wb_latency  out  CNT_WIDTH  cycles from launch to the matching write

## Operation
- States: IDLE, WAIT_WB, QUIET, DONE.
- IDLE: on check_start, latch exp_*, clear pass/fail_* and wb_latency, load cnt=0, go to WAIT_WB if exp_wr, otherwise go to QUIET (with macro) or DONE with pass=1 (without macro).
- WAIT_WB: cnt increments every cycle. Writes with wb_addr==0 are ignored.
  - wb_valid with wb_addr==exp_rd: wb_latency=cnt+1, compare full REG_WIDTH. Equal sets pass; unequal sets fail_mismatch. Go to QUIET (with macro) or DONE.
  - Write to another nonzero reg: with macro, set fail_spurious and stay (still waits for rd); without macro, ignore.
  - cnt+1==TIMEOUT_CYCLES with no matching write: fail_timeout, go to DONE. A matching write in that same cycle wins over the timeout.
- QUIET: counts QUIET_CYCLES. Any nonzero-reg write sets fail_spurious and clears pass. Exit to DONE.
- DONE: done=1 for one cycle, return to IDLE. Verdict flags hold until the next accepted check_start.
- check_start outside IDLE: ignored, sets protocol_err. protocol_err is cleared only by reset.
- busy=1 in WAIT_WB and QUIET.
- At most one of pass/fail_mismatch/fail_timeout is ever set. fail_spurious may coexist with fail_mismatch.

## Timing
- Reset (async assert, sync release on clk): state=IDLE; every output 0; cnt=0.
- check_start in cycle T: busy=1 from T+1.
- Writeback in cycle T+k (k≥1) yields wb_latency=k.
- Verdict flags are visible at T+k+1.
- done pulses at T+k+1 without the macro, and at T+k+1+QUIET_CYCLES with it.
- Timeout: done at T+TIMEOUT_CYCLES+1.
- A write in the check_start cycle itself is not observed.
- Reset mid-check aborts silently: no done pulse, and all flags are 0.

## Configuration
- FV_SI_SPURIOUS_WB_CHECK_EN defined: QUIET state and fail_spurious detection are present.
- Macro undefined: QUIET state is removed, fail_spurious is tied to 0, and writes to registers other than exp_rd are ignored.

## Test plan
- Macro off; start with exp_rd=5, exp_value=0x1234, exp_wr=1; write x5=0x1234 at T+3 -> wb_latency=3, pass=1, done at T+4.
- Write x5=0x1235 at T+2 -> fail_mismatch=1, pass=0, wb_latency=2.
- No write; TIMEOUT_CYCLES=64 -> fail_timeout=1 and done at T+65. Separately, a matching write at T+64 -> pass=1 and no timeout.
- Macro on; exp_wr=0 (store); write x7 at T+4 with QUIET_CYCLES=8 -> fail_spurious=1, pass=0, done at T+9. Write x0 instead -> pass=1.
- Second check_start at T+2 while busy -> protocol_err=1, original check completes unaffected.
- Assert reset_ low at T+2 mid-WAIT_WB -> all outputs 0 immediately, no done pulse, and a new start after release works normally.
